// File: rtl/u_lsu_resp.sv
// u_lsu_resp: turns one execute-stage LSU request into a single valid/ready
// data-memory bus transaction. Returns lane-extracted, zero-filled load data.
// Holds the execute stage via lsu_busy until the response cycle.
module u_lsu_resp #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  // execute-stage LSU side
  input  logic [31:0] lsu_a,
  input  logic [3:0]  lsu_we,
  input  logic [31:0] lsu_wd,
  input  logic [3:0]  lsu_re,
  output logic        lsu_vld,
  output logic [31:0] lsu_rd,
  output logic        lsu_err,
  output logic        lsu_busy,
  // data-memory bus side
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [29:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic        mem_gnt,
  input  logic        mem_rvld,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RDAT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Last waiting cycle before the timeout fires; the counter is 8 bits wide.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [29:0] a_q,   a_d;
  logic [3:0]  we_q,  we_d;
  logic [31:0] wd_q,  wd_d;
  logic [3:0]  re_q,  re_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rd_q,  rd_d;

  logic        req_in;
  logic        illegal_in;
  logic        timed_out;
  logic [31:0] rd_extract;

  // Byte offset bits never reach the word-addressed bus; lane enables carry that info.
  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, lsu_a[1:0]};

  // Only naturally aligned byte, halfword and word masks are supported.
  function automatic logic mask_ok(input logic [3:0] m);
    logic ok;
    case (m)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Zero the disabled lanes, then right-justify from the lowest enabled lane.
  function automatic logic [31:0] extract(input logic [3:0] re, input logic [31:0] d);
    logic [31:0] masked;
    logic [4:0]  shamt;
    for (int i = 0; i < 4; i++) begin
      masked[8*i +: 8] = re[i] ? d[8*i +: 8] : 8'h00;
    end
    casez (re)
      4'b???1: shamt = 5'd0;
      4'b??10: shamt = 5'd8;
      4'b?100: shamt = 5'd16;
      4'b1000: shamt = 5'd24;
      default: shamt = 5'd0;
    endcase
    return masked >> shamt;
  endfunction

  assign req_in     = (|lsu_we) | (|lsu_re);
  assign illegal_in = ((|lsu_we) & (|lsu_re)) | ~mask_ok(lsu_we | lsu_re);
  assign timed_out  = (cnt_q == TO_LAST);
  assign rd_extract = extract(re_q, mem_rd);

  // State and captured-request registers; rstn aborts any transaction silently.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      a_q     <= '0;
      we_q    <= '0;
      wd_q    <= '0;
      re_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      re_q    <= re_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  // Next-state logic: capture in IDLE, bus handshake in REQ/RDAT, one-cycle RESP.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    we_d    = we_q;
    wd_d    = wd_q;
    re_d    = re_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        if (req_in) begin
          a_d  = lsu_a[31:2];
          we_d = lsu_we;
          wd_d = lsu_wd;
          re_d = lsu_re;
          if (illegal_in) begin
            // Rejected without touching the bus.
            err_d   = 1'b1;
            rd_d    = '0;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          if (|we_q) begin
            state_d = RESP;
          end else begin
            cnt_d   = '0;
            state_d = RDAT;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          rd_d    = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RDAT: begin
        if (mem_rvld) begin
          rd_d    = rd_extract;
          state_d = RESP;
        end else if (timed_out) begin
          err_d   = 1'b1;
          rd_d    = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        // Execute registers advance at the end of this cycle, so no capture here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus and response outputs decoded from the registered state.
  always_comb begin
    mem_req  = (state_q == REQ);
    mem_we   = (state_q == REQ) ? we_q : 4'b0000;
    mem_a    = a_q;
    mem_wd   = wd_q;
    lsu_vld  = (state_q == RESP);
    lsu_err  = (state_q == RESP) & err_q;
    lsu_rd   = rd_q;
    // Combinational so the stall is already raised in the capture cycle.
    lsu_busy = ((state_q == IDLE) & req_in) | (state_q == REQ) | (state_q == RDAT);
  end

endmodule

// File: tb/tb_u_lsu_resp.sv
// Directed bench for u_lsu_resp. Stimulus pushes expected responses, bus
// transactions and per-cycle probes into queues; a negedge monitor consumes them.
`timescale 1ns/1ps
module tb_u_lsu_resp;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] lsu_a, lsu_wd, lsu_rd, mem_wd, mem_rd;
  logic [3:0]  lsu_we, lsu_re, mem_we;
  logic        lsu_vld, lsu_err, lsu_busy, mem_req, mem_gnt, mem_rvld;
  logic [29:0] mem_a;

  u_lsu_resp dut (
    .clk(clk), .rstn(rstn),
    .lsu_a(lsu_a), .lsu_we(lsu_we), .lsu_wd(lsu_wd), .lsu_re(lsu_re),
    .lsu_vld(lsu_vld), .lsu_rd(lsu_rd), .lsu_err(lsu_err), .lsu_busy(lsu_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_gnt(mem_gnt), .mem_rvld(mem_rvld), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic err; logic [31:0] rd; } resp_t;
  typedef struct { int cyc; logic [29:0] a; logic [3:0] we; logic [31:0] wd; } bus_t;
  typedef struct { int cyc; logic busy; logic req; logic [31:0] rd; } probe_t;

  resp_t  resp_q[$];
  bus_t   bus_q[$];
  probe_t probe_q[$];
  logic   done = 1'b0;
  logic [31:0] last_rd;

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int c, input logic busy, input logic req, input logic [31:0] rd);
    probe_q.push_back('{cyc: c, busy: busy, req: req, rd: rd});
  endtask

  task automatic clear_lsu();
    lsu_a = '0; lsu_we = '0; lsu_wd = '0; lsu_re = '0;
  endtask

  // One full request; leaves inputs cleared in the cycle after RESP so the next
  // call presents its request on the very next release.
  task automatic run_txn(input logic [31:0] a, input logic [3:0] we, input logic [3:0] re,
                         input logic [31:0] wd, input int gnt_wait, input int rvld_wait,
                         input logic [31:0] rdata, input logic [31:0] exp_rd,
                         input logic illegal);
    logic [29:0] wa;
    wa = a[31:2];
    lsu_a = a; lsu_we = we; lsu_re = re; lsu_wd = wd;
    probe(cyc, 1'b1, 1'b0, last_rd);
    tick();
    if (illegal) begin
      last_rd = '0;
      probe(cyc, 1'b0, 1'b0, last_rd);
      resp_q.push_back('{cyc: cyc, err: 1'b1, rd: 32'h0});
    end else begin
      for (int i = 0; i < gnt_wait; i++) begin
        probe(cyc, 1'b1, 1'b1, last_rd);
        tick();
      end
      mem_gnt = 1'b1;
      bus_q.push_back('{cyc: cyc, a: wa, we: we, wd: wd});
      probe(cyc, 1'b1, 1'b1, last_rd);
      tick();
      mem_gnt = 1'b0;
      if (|re) begin
        for (int i = 0; i < rvld_wait; i++) begin
          probe(cyc, 1'b1, 1'b0, last_rd);
          tick();
        end
        mem_rvld = 1'b1;
        mem_rd   = rdata;
        probe(cyc, 1'b1, 1'b0, last_rd);
        tick();
        mem_rvld = 1'b0;
        last_rd  = exp_rd;
      end
      probe(cyc, 1'b0, 1'b0, last_rd);
      resp_q.push_back('{cyc: cyc, err: 1'b0, rd: last_rd});
    end
    tick();
    clear_lsu();
  endtask

  initial begin
    int c0;
    rstn = 1'b0; mem_gnt = 1'b0; mem_rvld = 1'b0; mem_rd = '0;
    clear_lsu();
    last_rd = '0;
    tick();
    probe(cyc, 1'b0, 1'b0, 32'h0);
    tick();
    rstn = 1'b1;
    tick();

    // sw: store word at 0x100, granted in cycle 1 -> response in cycle 2
    run_txn(32'h100, 4'b1111, 4'b0000, 32'h12345678, 0, 0, 32'h0, 32'h0, 1'b0);
    tick();
    // lhu at 0x202: gnt cycle 1, rvld cycle 3 -> response in cycle 4
    run_txn(32'h202, 4'b0000, 4'b1100, 32'h0, 0, 1, 32'hAABBCCDD, 32'h0000AABB, 1'b0);
    tick();
    // Illegal load mask 0101 clears lsu_rd and never requests the bus
    run_txn(32'h40, 4'b0000, 4'b0101, 32'h0, 0, 0, 32'h0, 32'h0, 1'b1);
    // lbu lane 1
    run_txn(32'h1, 4'b0000, 4'b0010, 32'h0, 0, 0, 32'h11223344, 32'h00000033, 1'b0);
    // sb with grant delay; lsu_rd must hold 0x33
    run_txn(32'h2, 4'b0100, 4'b0000, 32'h00AB0000, 2, 0, 32'h0, 32'h0, 1'b0);
    // Back-to-back store then load
    run_txn(32'h10, 4'b1100, 4'b0000, 32'hBEEF0000, 0, 0, 32'h0, 32'h0, 1'b0);
    run_txn(32'h14, 4'b0000, 4'b1111, 32'h0, 1, 0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    // Store and load enabled together, then an unaligned store mask
    run_txn(32'h20, 4'b0001, 4'b0001, 32'h0, 0, 0, 32'h0, 32'h0, 1'b1);
    run_txn(32'h24, 4'b0110, 4'b0000, 32'h0, 0, 0, 32'h0, 32'h0, 1'b1);
    // lbu lane 3, top bit set stays zero-filled
    run_txn(32'h33, 4'b0000, 4'b1000, 32'h0, 0, 2, 32'h80FF0000, 32'h00000080, 1'b0);
    tick();

    // Load granted, rvld never arrives: 255 RDAT cycles then error response
    c0 = cyc;
    lsu_a = 32'h300; lsu_re = 4'b1111;
    probe(c0, 1'b1, 1'b0, last_rd);
    tick();
    mem_gnt = 1'b1;
    bus_q.push_back('{cyc: cyc, a: 30'h0C0, we: 4'b0000, wd: 32'h0});
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 255; i++) begin
      if (i == 0 || i == 254) probe(cyc, 1'b1, 1'b0, last_rd);
      tick();
    end
    last_rd = '0;
    probe(c0 + 257, 1'b0, 1'b0, 32'h0);
    resp_q.push_back('{cyc: c0 + 257, err: 1'b1, rd: 32'h0});
    // Late read data must be ignored outside RDAT, including during a store
    mem_rvld = 1'b1; mem_rd = 32'hDEADBEEF;
    tick();
    clear_lsu();
    tick();
    run_txn(32'h44, 4'b0011, 4'b0000, 32'h0000BEEF, 1, 0, 32'h0, 32'h0, 1'b0);
    mem_rvld = 1'b0;
    tick();

    // Store never granted: 255 REQ cycles then error response
    c0 = cyc;
    lsu_a = 32'h104; lsu_we = 4'b0011; lsu_wd = 32'h00005555;
    probe(c0, 1'b1, 1'b0, last_rd);
    tick();
    probe(c0 + 1, 1'b1, 1'b1, last_rd);
    for (int i = 0; i < 255; i++) tick();
    probe(c0 + 256, 1'b0, 1'b0, 32'h0);
    resp_q.push_back('{cyc: c0 + 256, err: 1'b1, rd: 32'h0});
    tick();
    clear_lsu();
    tick();

    // Load with a set result, then reset while waiting in RDAT
    run_txn(32'h50, 4'b0000, 4'b0001, 32'h0, 0, 0, 32'h000000A5, 32'h000000A5, 1'b0);
    c0 = cyc;
    lsu_a = 32'h208; lsu_re = 4'b0001;
    tick();
    mem_gnt = 1'b1;
    bus_q.push_back('{cyc: cyc, a: 30'h082, we: 4'b0000, wd: 32'h0});
    tick();
    mem_gnt = 1'b0;
    probe(cyc, 1'b1, 1'b0, last_rd);
    tick();
    rstn = 1'b0;
    clear_lsu();
    last_rd = '0;
    probe(cyc, 1'b0, 1'b0, 32'h0);
    tick();
    probe(cyc, 1'b0, 1'b0, 32'h0);
    rstn = 1'b1;
    tick();
    run_txn(32'h208, 4'b0000, 4'b0011, 32'h0, 0, 0, 32'h1234ABCD, 32'h0000ABCD, 1'b0);
    repeat (3) tick();
    done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int r_i = 0, b_i = 0, p_i = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done || cyc > 20000) begin
      if (!done) chk("watchdog_done", 32'd0, 32'd1);
      chk("resp_drained", 32'(r_i), 32'(resp_q.size()));
      chk("bus_drained", 32'(b_i), 32'(bus_q.size()));
      chk("probe_drained", 32'(p_i), 32'(probe_q.size()));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end else begin
      while (p_i < probe_q.size() && probe_q[p_i].cyc <= cyc) begin
        if (probe_q[p_i].cyc < cyc) begin
          chk("probe_missed", 32'(cyc), 32'(probe_q[p_i].cyc));
        end else begin
          chk("busy", {31'd0, lsu_busy}, {31'd0, probe_q[p_i].busy});
          chk("mem_req", {31'd0, mem_req}, {31'd0, probe_q[p_i].req});
          chk("lsu_rd_hold", lsu_rd, probe_q[p_i].rd);
        end
        p_i++;
      end
      if (lsu_err && !lsu_vld) chk("err_without_vld", 32'd1, 32'd0);
      if (lsu_vld) begin
        $display("resp cyc=%0d err=%0b rd=%h", cyc, lsu_err, lsu_rd);
        if (r_i < resp_q.size()) begin
          chk("resp_cycle", 32'(cyc), 32'(resp_q[r_i].cyc));
          chk("resp_err", {31'd0, lsu_err}, {31'd0, resp_q[r_i].err});
          chk("resp_rd", lsu_rd, resp_q[r_i].rd);
          r_i++;
        end else begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end
      end
      if (mem_req && mem_gnt) begin
        $display("bus cyc=%0d a=%h we=%b wd=%h", cyc, mem_a, mem_we, mem_wd);
        if (b_i < bus_q.size()) begin
          chk("bus_cycle", 32'(cyc), 32'(bus_q[b_i].cyc));
          chk("bus_a", {2'b00, mem_a}, {2'b00, bus_q[b_i].a});
          chk("bus_we", {28'd0, mem_we}, {28'd0, bus_q[b_i].we});
          chk("bus_wd", mem_wd, bus_q[b_i].wd);
          b_i++;
        end else begin
          chk("unexpected_bus", 32'd1, 32'd0);
        end
      end
    end
  end

endmodule
